// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA timing generator from a 50 MHz clock
// Counters advance every other Clk; syncs/blank are registered from next-state counts.
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic       Clk,
   input  logic       Reset_n,
   output logic       pixel_clk,
   output logic       hs,
   output logic       vs,
   output logic       blank_n,
   output logic       sync_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       frame_start
);

   localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
   localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] H_TOTAL      = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
   localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
   localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [9:0] V_TOTAL      = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);

   logic       ph;
   logic [9:0] hc;
   logic [9:0] vc;
   logic [9:0] hc_nxt;
   logic [9:0] vc_nxt;
   logic       h_last;
   logic       v_last;
   logic       wrap;

   // End-of-line/frame detected as count+1 == total so no subtraction is needed.
   assign h_last = ((hc + 10'd1) == H_TOTAL);
   assign v_last = ((vc + 10'd1) == V_TOTAL);
   assign wrap   = ph & h_last & v_last;

   always_comb begin
      hc_nxt = hc;
      vc_nxt = vc;
      if (ph) begin
         if (h_last) begin
            hc_nxt = 10'd0;
            vc_nxt = v_last ? 10'd0 : vc + 10'd1;
         end else begin
            hc_nxt = hc + 10'd1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ph          <= 1'b0;
         hc          <= 10'd0;
         vc          <= 10'd0;
         hs          <= 1'b1;
         vs          <= 1'b1;
         blank_n     <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         ph          <= ~ph;
         hc          <= hc_nxt;
         vc          <= vc_nxt;
         hs          <= ~((hc_nxt >= H_SYNC_START) && (hc_nxt < H_SYNC_END));
         vs          <= ~((vc_nxt >= V_SYNC_START) && (vc_nxt < V_SYNC_END));
         blank_n     <= (hc_nxt < H_VIS_END) && (vc_nxt < V_VIS_END);
         frame_start <= wrap;
      end
   end

   assign pixel_clk = ph;
   assign sync_n    = 1'b0;
   assign DrawX     = hc;
   assign DrawY     = vc;

endmodule
